// File: rtl/lru_repl_pkg.sv
// Shared types and constants for the L1 replacement controller.
// Descriptor fields are sized for the largest supported geometry; users slice them.
package lru_repl_pkg;

    localparam int PERF_CNT_WIDTH      = 32;
    localparam int MAX_WAYS            = 8;
    localparam int MAX_TAG_WIDTH       = 64;
    localparam int MAX_SET_INDEX_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EVICT,
        FILL_REQ,
        FILL_WAIT,
        UPDATE
    } repl_state_t;

    typedef struct packed {
        logic [MAX_SET_INDEX_WIDTH-1:0]    set;
        logic [MAX_TAG_WIDTH-1:0]          tag;
        logic [MAX_WAYS-1:0]               valids;
        logic [MAX_WAYS-1:0]               dirty;
        logic [MAX_WAYS*MAX_TAG_WIDTH-1:0] tags;
    } miss_desc_t;

endpackage

// File: rtl/lru_replacement_ctrl_sat_counter.sv
// Saturating up-counter used for the optional performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/lru_replacement_ctrl.sv
// Replacement controller between L1 tag lookup and the tree-PLRU state block.
// Optional perf counters are enabled by defining LRU_REPL_CTRL_PERF_EN.
module lru_replacement_ctrl
    import lru_repl_pkg::*;
#(
    parameter int NUM_SETS        = 32,
    parameter int NUM_WAYS        = 4,
    parameter int TAG_WIDTH       = 20,
    parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
    parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           lookup_valid,
    output logic                           lookup_ready,
    input  logic [SET_INDEX_WIDTH-1:0]     lookup_set,
    input  logic [TAG_WIDTH-1:0]           lookup_tag,
    input  logic                           lookup_hit,
    input  logic [WAY_INDEX_WIDTH-1:0]     lookup_hit_way,
    input  logic [NUM_WAYS-1:0]            lookup_valids,
    input  logic [NUM_WAYS-1:0]            lookup_dirty,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]  lookup_tags,
    output logic                           plru_read_en,
    output logic [SET_INDEX_WIDTH-1:0]     plru_read_set,
    output logic [NUM_WAYS-1:0]            plru_read_valids,
    input  logic [WAY_INDEX_WIDTH-1:0]     plru_read_way,
    output logic                           plru_update_en,
    output logic [SET_INDEX_WIDTH-1:0]     plru_update_set,
    output logic [WAY_INDEX_WIDTH-1:0]     plru_update_way,
    output logic                           evict_valid,
    input  logic                           evict_ready,
    output logic [SET_INDEX_WIDTH-1:0]     evict_set,
    output logic [WAY_INDEX_WIDTH-1:0]     evict_way,
    output logic [TAG_WIDTH-1:0]           evict_tag,
    output logic                           fill_valid,
    input  logic                           fill_ready,
    output logic [SET_INDEX_WIDTH-1:0]     fill_set,
    output logic [WAY_INDEX_WIDTH-1:0]     fill_way,
    output logic [TAG_WIDTH-1:0]           fill_tag,
    input  logic                           fill_done,
`ifdef LRU_REPL_CTRL_PERF_EN
    output logic [PERF_CNT_WIDTH-1:0]      perf_hits,
    output logic [PERF_CNT_WIDTH-1:0]      perf_misses,
    output logic [PERF_CNT_WIDTH-1:0]      perf_evictions,
`endif
    output logic                           busy
);

    repl_state_t                state_reg, state_next;
    miss_desc_t                 desc_reg, desc_next;
    logic [WAY_INDEX_WIDTH-1:0] victim_way_reg;
    logic [WAY_INDEX_WIDTH-1:0] sel_way;
    logic                       upd_en_reg;
    logic [SET_INDEX_WIDTH-1:0] upd_set_reg;
    logic [WAY_INDEX_WIDTH-1:0] upd_way_reg;
    logic                       accept;
    logic                       hit_accept;
    logic                       miss_accept;

    // A single-way cache has only one possible victim.
    generate
        if (NUM_WAYS == 1) begin : g_one_way
            assign sel_way = '0;
        end else begin : g_multi_way
            assign sel_way = plru_read_way;
        end
    endgenerate

    assign lookup_ready = (state_reg == IDLE);
    assign accept       = lookup_valid && lookup_ready;
    assign hit_accept   = accept && lookup_hit;
    assign miss_accept  = accept && !lookup_hit;
    assign busy         = (state_reg != IDLE);

    always_comb begin
        desc_next                                = '0;
        desc_next.set[SET_INDEX_WIDTH-1:0]       = lookup_set;
        desc_next.tag[TAG_WIDTH-1:0]             = lookup_tag;
        desc_next.valids[NUM_WAYS-1:0]           = lookup_valids;
        desc_next.dirty[NUM_WAYS-1:0]            = lookup_dirty;
        desc_next.tags[NUM_WAYS*TAG_WIDTH-1:0]   = lookup_tags;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (miss_accept) state_next = SELECT;
            SELECT: begin
                if (desc_reg.valids[sel_way] && desc_reg.dirty[sel_way]) state_next = EVICT;
                else                                                     state_next = FILL_REQ;
            end
            EVICT:     if (evict_ready) state_next = FILL_REQ;
            FILL_REQ:  if (fill_ready)  state_next = FILL_WAIT;
            FILL_WAIT: if (fill_done)   state_next = UPDATE;
            UPDATE:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            desc_reg       <= '0;
            victim_way_reg <= '0;
            upd_en_reg     <= 1'b0;
            upd_set_reg    <= '0;
            upd_way_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (miss_accept) begin
                desc_reg <= desc_next;
            end
            if (state_reg == SELECT) begin
                victim_way_reg <= sel_way;
            end
            // Hits and refill completion can never overlap: lookups are blocked while busy.
            upd_en_reg <= hit_accept || ((state_reg == FILL_WAIT) && fill_done);
            if (hit_accept) begin
                upd_set_reg <= lookup_set;
                upd_way_reg <= lookup_hit_way;
            end else if ((state_reg == FILL_WAIT) && fill_done) begin
                upd_set_reg <= desc_reg.set[SET_INDEX_WIDTH-1:0];
                upd_way_reg <= victim_way_reg;
            end
        end
    end

    assign plru_read_en     = (state_reg == SELECT);
    assign plru_read_set    = desc_reg.set[SET_INDEX_WIDTH-1:0];
    assign plru_read_valids = desc_reg.valids[NUM_WAYS-1:0];

    assign plru_update_en   = upd_en_reg;
    assign plru_update_set  = upd_set_reg;
    assign plru_update_way  = upd_way_reg;

    assign evict_valid = (state_reg == EVICT);
    assign evict_set   = desc_reg.set[SET_INDEX_WIDTH-1:0];
    assign evict_way   = victim_way_reg;
    assign evict_tag   = desc_reg.tags[int'(victim_way_reg)*TAG_WIDTH +: TAG_WIDTH];

    assign fill_valid  = (state_reg == FILL_REQ);
    assign fill_set    = desc_reg.set[SET_INDEX_WIDTH-1:0];
    assign fill_way    = victim_way_reg;
    assign fill_tag    = desc_reg.tag[TAG_WIDTH-1:0];

`ifdef LRU_REPL_CTRL_PERF_EN
    logic [2:0]                perf_inc;
    logic [PERF_CNT_WIDTH-1:0] perf_cnt [3];

    assign perf_inc[0] = hit_accept;
    assign perf_inc[1] = miss_accept;
    assign perf_inc[2] = evict_valid && evict_ready;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            sat_counter #(
                .WIDTH (PERF_CNT_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (perf_inc[gi]),
                .count (perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_hits      = perf_cnt[0];
    assign perf_misses    = perf_cnt[1];
    assign perf_evictions = perf_cnt[2];
`endif

endmodule
